// File: rtl/instr_fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: default widths and the bubble instruction.
// Each stored entry is packed as {prediction, pc, instr}.
package instr_fetch_queue_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0033;  // add x0,x0,x0

  function automatic int entry_width(input int xlen);
    return 2 * xlen + 1;
  endfunction

endpackage

// File: rtl/ifq_storage.sv
// Register array for the fetch queue: one synchronous write port, one asynchronous read port.
// Contents are never reset; the queue masks stale entries with its valid flag.
module ifq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 65,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; clearing it would cost a mux per bit and
  // the valid flag already hides unwritten entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Show-ahead instruction queue between instruction memory and decode, with stall and flush.
// The head entry appears combinationally; an empty queue presents a NOP bubble.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEF,
  parameter int               DEPTH     = 4,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEF),
  localparam int              CW        = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_imem_vld,
  input  logic [XLEN-1:0] i_imem_instr,
  input  logic [XLEN-1:0] i_imem_pc,
  input  logic            i_imem_pred,
  output logic            o_imem_rdy,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic            o_vld,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic            o_prediction,
  output logic [CW-1:0]   o_count
);

  localparam int            PW      = $clog2(DEPTH);
  localparam int            EW      = entry_width(XLEN);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          out_of_reset;
  logic          enq, deq;
  logic [EW-1:0] head_entry;

  // Ready depends only on flops so flush/stall never reach the memory handshake.
  assign o_imem_rdy = out_of_reset && (count < FULL_C);
  assign o_vld      = (count != '0);
  assign o_count    = count;

  assign enq = i_imem_vld && o_imem_rdy && !i_flush;
  assign deq = o_vld && !i_stall && !i_flush;

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values of enq/deq and the pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      out_of_reset <= 1'b0;
    end else begin
      out_of_reset <= 1'b1;
      if (i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
        case ({enq, deq})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  ifq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_storage (
    .clk     (clk),
    .wr_en   (enq),
    .wr_addr (wr_ptr),
    .wr_data ({i_imem_pred, i_imem_pc, i_imem_instr}),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    o_instr      = NOP_INSTR;
    o_pc         = '0;
    o_prediction = 1'b0;
    if (o_vld) begin
      o_instr      = head_entry[XLEN-1:0];
      o_pc         = head_entry[2*XLEN-1:XLEN];
      o_prediction = head_entry[EW-1];
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: flow, full, stall, flush, wrap-around and async reset.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_imem_vld;
  logic [31:0] i_imem_instr;
  logic [31:0] i_imem_pc;
  logic        i_imem_pred;
  logic        o_imem_rdy;
  logic        i_stall;
  logic        i_flush;
  logic        o_vld;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_prediction;
  logic [2:0]  o_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.XLEN(32), .DEPTH(4), .NOP_INSTR(32'h0000_0033)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_imem_vld   (i_imem_vld),
    .i_imem_instr (i_imem_instr),
    .i_imem_pc    (i_imem_pc),
    .i_imem_pred  (i_imem_pred),
    .o_imem_rdy   (o_imem_rdy),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .o_vld        (o_vld),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_prediction (o_prediction),
    .o_count      (o_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] pc,
                       input logic pred, input logic stall, input logic flush);
    i_imem_vld   = vld;
    i_imem_instr = instr;
    i_imem_pc    = pc;
    i_imem_pred  = pred;
    i_stall      = stall;
    i_flush      = flush;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_instr [10];
  logic [31:0] exp_pc    [10];
  logic        exp_pred  [10];

  initial begin
    int sent, recv, cyc;
    logic stall;

    rst_n = 1'b0;
    idle();

    // Reset state
    #2;
    check("rst_vld",   64'(o_vld), 64'(0));
    check("rst_instr", 64'(o_instr), 64'h33);
    check("rst_pc",    64'(o_pc), 64'(0));
    check("rst_pred",  64'(o_prediction), 64'(0));
    check("rst_count", 64'(o_count), 64'(0));
    check("rst_rdy",   64'(o_imem_rdy), 64'(0));
    #10 rst_n = 1'b1;
    tick();
    check("rdy_after_rst", 64'(o_imem_rdy), 64'(1));

    // Basic flow: one-cycle latency, then steady flow at count 1
    drive(1'b1, 32'h0051_8233, 32'h4, 1'b0, 1'b0, 1'b0);
    check("flow_no_bypass", 64'(o_vld), 64'(0));
    tick();
    check("flow_vld1",   64'(o_vld), 64'(1));
    check("flow_instr1", 64'(o_instr), 64'h0051_8233);
    check("flow_pc1",    64'(o_pc), 64'h4);
    check("flow_cnt1",   64'(o_count), 64'(1));
    drive(1'b1, 32'h4053_03b3, 32'h8, 1'b0, 1'b0, 1'b0);
    tick();
    check("flow_instr2", 64'(o_instr), 64'h4053_03b3);
    check("flow_pc2",    64'(o_pc), 64'h8);
    check("flow_cnt2",   64'(o_count), 64'(1));
    idle();
    tick();
    check("flow_empty", 64'(o_vld), 64'(0));

    // Fill to full under stall; 5th beat refused
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'(i * 4), 1'b0, 1'b1, 1'b0);
      check($sformatf("fill_rdy%0d", i), 64'(o_imem_rdy), (i < 4) ? 64'(1) : 64'(0));
      tick();
    end
    check("full_count", 64'(o_count), 64'(4));
    check("full_rdy",   64'(o_imem_rdy), 64'(0));
    check("full_head",  64'(o_instr), 64'h100);
    idle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain_instr%0d", k), 64'(o_instr), 64'h100 + 64'(k));
      if (k == 0) check("full_deq_rdy", 64'(o_imem_rdy), 64'(0));
      if (k == 1) check("rdy_after_deq", 64'(o_imem_rdy), 64'(1));
      tick();
    end
    check("fifth_dropped", 64'(o_vld), 64'(0));

    // Load-use stall holds the head for two cycles
    drive(1'b1, 32'h0081_a303, 32'h10, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0043_03b3, 32'h14, 1'b0, 1'b1, 1'b0);
    check("lu_head_c1", 64'(o_instr), 64'h0081_a303);
    tick();
    idle();
    check("lu_head_c2", 64'(o_instr), 64'h0081_a303);
    check("lu_count",   64'(o_count), 64'(2));
    tick();
    check("lu_next",    64'(o_instr), 64'h0043_03b3);
    check("lu_next_pc", 64'(o_pc), 64'h14);
    tick();
    check("lu_empty",   64'(o_count), 64'(0));

    // Flush with a beat offered in the same cycle
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h200 + 32'(i), 32'h40 + 32'(i * 4), 1'b1, 1'b1, 1'b0);
      tick();
    end
    check("pre_flush_cnt", 64'(o_count), 64'(3));
    drive(1'b1, 32'h0053_8463, 32'h50, 1'b1, 1'b1, 1'b1);
    tick();
    idle();
    check("flush_cnt",   64'(o_count), 64'(0));
    check("flush_vld",   64'(o_vld), 64'(0));
    check("flush_instr", 64'(o_instr), 64'h33);
    check("flush_pc",    64'(o_pc), 64'(0));
    check("flush_pred",  64'(o_prediction), 64'(0));
    tick();
    check("beq_dropped", 64'(o_count), 64'(0));

    // Wrap-around stream with random stalls
    for (int i = 0; i < 10; i++) begin
      exp_instr[i] = 32'hA000_0000 + 32'(i);
      exp_pc[i]    = 32'(i * 4);
      exp_pred[i]  = (i % 2) == 1;
    end
    sent = 0;
    recv = 0;
    cyc  = 0;
    while (recv < 10 && cyc < 200) begin
      stall = ($urandom_range(0, 3) == 0);
      if (sent < 10) drive(1'b1, exp_instr[sent], exp_pc[sent], exp_pred[sent], stall, 1'b0);
      else           drive(1'b0, 32'h0, 32'h0, 1'b0, stall, 1'b0);
      if (o_vld && !stall) begin
        check($sformatf("wrap_instr%0d", recv), 64'(o_instr), 64'(exp_instr[recv]));
        check($sformatf("wrap_pc%0d", recv),    64'(o_pc), 64'(exp_pc[recv]));
        check($sformatf("wrap_pred%0d", recv),  64'(o_prediction), 64'(exp_pred[recv]));
        recv++;
      end
      if (sent < 10 && o_imem_rdy) sent++;
      tick();
      cyc++;
    end
    check("wrap_all_recv", 64'(recv), 64'(10));
    idle();
    tick();
    check("wrap_empty", 64'(o_vld), 64'(0));

    // Asynchronous reset with two entries queued
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h300 + 32'(i), 32'h80 + 32'(i * 4), 1'b0, 1'b1, 1'b0);
      tick();
    end
    idle();
    check("ar_pre_cnt", 64'(o_count), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    check("ar_vld",   64'(o_vld), 64'(0));
    check("ar_count", 64'(o_count), 64'(0));
    check("ar_rdy",   64'(o_imem_rdy), 64'(0));
    check("ar_instr", 64'(o_instr), 64'h33);
    #10 rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
